// File: rtl/bf_pipe.sv
// bf_pipe: pipelined radix-2 butterfly with valid/ready flow control.
// Optional transfer counter built when BF_PIPE_COUNT_EN is defined.
module bf_pipe #(
  parameter int NBITS = 10,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_scale,
  input  logic [2*NBITS-1:0]       i_up,
  input  logic [2*NBITS-1:0]       i_down,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*(NBITS+1)-1:0]   o_up,
  output logic [2*(NBITS+1)-1:0]   o_down,
  output logic [15:0]              o_count
);

  localparam int NB = NBITS;
  localparam int OW = NBITS + 1;
  localparam int PW = 2 * OW;
  localparam logic [NB+1:0] ONE = {{(NB+1){1'b0}}, 1'b1};

  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("bf_pipe: LAT must be in 1..4");
  end

  // One component: sign-extend, add or subtract, optional round-half-up halving
  function automatic logic [OW-1:0] bf(
    input logic [NB-1:0] a,
    input logic [NB-1:0] b,
    input logic          sub,
    input logic          sc
  );
    logic [NB+1:0] ax;
    logic [NB+1:0] bx;
    logic [NB+1:0] s;
    logic [NB+1:0] t;
    ax = {{2{a[NB-1]}}, a};
    bx = {{2{b[NB-1]}}, b};
    s  = sub ? (ax - bx) : (ax + bx);
    t  = s + ONE;
    bf = sc ? t[NB+1:1] : s[NB:0];
  endfunction

  logic [LAT-1:0] vld_q;
  logic [PW-1:0]  up_q [LAT];
  logic [PW-1:0]  dn_q [LAT];
  logic [PW-1:0]  up_d;
  logic [PW-1:0]  dn_d;
  logic           stall;
  logic           accept;

  assign stall   = o_valid & ~i_ready;
  assign o_ready = ~stall;
  assign accept  = i_valid & o_ready;

  // Butterfly arithmetic on the incoming pair; scale applied at acceptance
  always_comb begin
    up_d = {bf(i_up[2*NB-1:NB], i_down[2*NB-1:NB], 1'b0, i_scale),
            bf(i_up[NB-1:0],    i_down[NB-1:0],    1'b0, i_scale)};
    dn_d = {bf(i_up[2*NB-1:NB], i_down[2*NB-1:NB], 1'b1, i_scale),
            bf(i_up[NB-1:0],    i_down[NB-1:0],    1'b1, i_scale)};
  end

  // Pipeline: all stages advance together unless the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        up_q[i] <= '0;
        dn_q[i] <= '0;
      end
    end else if (!stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1];
        up_q[i]  <= up_q[i-1];
        dn_q[i]  <= dn_q[i-1];
      end
      vld_q[0] <= accept;
      if (accept) begin
        up_q[0] <= up_d;
        dn_q[0] <= dn_d;
      end
    end
  end

  assign o_valid = vld_q[LAT-1];
  assign o_up    = up_q[LAT-1];
  assign o_down  = dn_q[LAT-1];

`ifdef BF_PIPE_COUNT_EN
  logic [15:0] count_q;

  // Count completed output transfers, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (o_valid && i_ready) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign o_count = count_q;
`else
  assign o_count = 16'h0000;
`endif

endmodule
